// File: rtl/axi_mem_arbiter.sv
// axi_mem_arbiter: round-robin arbiter sharing one AXI4 master among N_PORTS requestors, one transaction at a time
// Ports: clk/reset (async, active-low); req_* per-port request bus (flattened, port i in slice i);
// rsp_* registered response pulse to the owning port; m_axi_* AR/R/AW/W/B master channels.
module axi_mem_arbiter #(
  parameter int N_PORTS    = 2,
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_PORTS-1:0]           req_valid,
  output logic [N_PORTS-1:0]           req_ready,
  input  logic [N_PORTS-1:0]           req_write,
  input  logic [N_PORTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_PORTS*DATA_WIDTH-1:0] req_wdata,
  input  logic [N_PORTS*STRB_WIDTH-1:0] req_wstrb,
  input  logic [N_PORTS*8-1:0]         req_len,
  output logic [N_PORTS-1:0]           rsp_valid,
  output logic [DATA_WIDTH-1:0]        rsp_data,
  output logic                         rsp_last,
  output logic                         rsp_err,
  output logic [ID_WIDTH-1:0]          m_axi_arid,
  output logic [ADDR_WIDTH-1:0]        m_axi_araddr,
  output logic [7:0]                   m_axi_arlen,
  output logic [2:0]                   m_axi_arsize,
  output logic [1:0]                   m_axi_arburst,
  output logic                         m_axi_arvalid,
  input  logic                         m_axi_arready,
  input  logic [DATA_WIDTH-1:0]        m_axi_rdata,
  input  logic [1:0]                   m_axi_rresp,
  input  logic                         m_axi_rlast,
  input  logic                         m_axi_rvalid,
  output logic                         m_axi_rready,
  output logic [ID_WIDTH-1:0]          m_axi_awid,
  output logic [ADDR_WIDTH-1:0]        m_axi_awaddr,
  output logic [7:0]                   m_axi_awlen,
  output logic [2:0]                   m_axi_awsize,
  output logic [1:0]                   m_axi_awburst,
  output logic                         m_axi_awvalid,
  input  logic                         m_axi_awready,
  output logic [DATA_WIDTH-1:0]        m_axi_wdata,
  output logic [STRB_WIDTH-1:0]        m_axi_wstrb,
  output logic                         m_axi_wlast,
  output logic                         m_axi_wvalid,
  input  logic                         m_axi_wready,
  input  logic [1:0]                   m_axi_bresp,
  input  logic                         m_axi_bvalid,
  output logic                         m_axi_bready
);
  localparam int PW = N_PORTS > 1 ? $clog2(N_PORTS) : 1;
  localparam logic [2:0] IDLE = 3'd0, RD_ADDR = 3'd1, RD_DATA = 3'd2, WR_REQ = 3'd3, WR_RESP = 3'd4;
  localparam logic [2:0] SIZE = 3'($clog2(STRB_WIDTH));
  logic [2:0] state;
  logic [PW-1:0] rr_ptr, g, gnt;
  logic [N_PORTS-1:0] rot, g_oh, gnt_oh;
  logic found, aw_done, w_done, aw_now, w_now;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic [7:0] len;
  // Rotate so bit k is port (rr_ptr + k) mod N_PORTS; the lowest set bit wins.
  assign rot = N_PORTS'({req_valid, req_valid} >> rr_ptr);
  always_comb begin
    found = 1'b0;
    gnt = '0;
    for (int k = 0; k < N_PORTS; k++)
      if (!found && rot[k]) begin
        found = 1'b1;
        gnt = PW'((int'(rr_ptr) + k) % N_PORTS);
      end
  end
  assign g_oh = N_PORTS'(1) << g;
  assign gnt_oh = N_PORTS'(1) << gnt;
  // Gated by reset so no request is accepted while the block is held in reset.
  assign req_ready = (reset && state == IDLE && found) ? gnt_oh : '0;
  assign m_axi_arid = ID_WIDTH'(g);
  assign m_axi_araddr = addr;
  assign m_axi_arlen = len;
  assign m_axi_arsize = SIZE;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arvalid = state == RD_ADDR;
  assign m_axi_rready = state == RD_DATA;
  assign m_axi_awid = ID_WIDTH'(g);
  assign m_axi_awaddr = addr;
  assign m_axi_awlen = 8'd0;
  assign m_axi_awsize = SIZE;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awvalid = state == WR_REQ && !aw_done;
  assign m_axi_wdata = wdata;
  assign m_axi_wstrb = wstrb;
  assign m_axi_wlast = 1'b1;
  assign m_axi_wvalid = state == WR_REQ && !w_done;
  assign m_axi_bready = state == WR_RESP;
  // AW and W complete independently, possibly in the same cycle.
  assign aw_now = aw_done || (m_axi_awvalid && m_axi_awready);
  assign w_now = w_done || (m_axi_wvalid && m_axi_wready);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      g <= '0;
      addr <= '0;
      wdata <= '0;
      wstrb <= '0;
      len <= '0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      rsp_valid <= '0;
      rsp_data <= '0;
      rsp_last <= 1'b0;
      rsp_err <= 1'b0;
    end else begin
      rsp_valid <= '0;
      rsp_data <= '0;
      rsp_last <= 1'b0;
      rsp_err <= 1'b0;
      case (state)
        IDLE:
          if (found) begin
            g <= gnt;
            addr <= req_addr[gnt*ADDR_WIDTH +: ADDR_WIDTH];
            wdata <= req_wdata[gnt*DATA_WIDTH +: DATA_WIDTH];
            wstrb <= req_wstrb[gnt*STRB_WIDTH +: STRB_WIDTH];
            len <= req_len[gnt*8 +: 8];
            aw_done <= 1'b0;
            w_done <= 1'b0;
            rr_ptr <= gnt == PW'(N_PORTS - 1) ? '0 : gnt + 1'b1;
            state <= req_write[gnt] ? WR_REQ : RD_ADDR;
          end
        RD_ADDR: state <= m_axi_arready ? RD_DATA : RD_ADDR;
        RD_DATA:
          if (m_axi_rvalid) begin
            rsp_valid <= g_oh;
            rsp_data <= m_axi_rdata;
            rsp_last <= m_axi_rlast;
            rsp_err <= |m_axi_rresp;
            state <= m_axi_rlast ? IDLE : RD_DATA;
          end
        WR_REQ: begin
          aw_done <= aw_now;
          w_done <= w_now;
          state <= (aw_now && w_now) ? WR_RESP : WR_REQ;
        end
        WR_RESP:
          if (m_axi_bvalid) begin
            rsp_valid <= g_oh;
            rsp_last <= 1'b1;
            rsp_err <= |m_axi_bresp;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_axi_mem_arbiter.sv
// tb_axi_mem_arbiter: self-checking bench for axi_mem_arbiter (vector table, directed corners, random vs reference model)
module tb_axi_mem_arbiter;
  localparam int N = 2, IW = 13, AW = 64, DW = 64, SW = 8;
  logic clk = 1'b0, reset;
  logic [N-1:0] req_valid, req_ready, req_write, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*SW-1:0] req_wstrb;
  logic [N*8-1:0] req_len;
  logic [DW-1:0] rsp_data, rdata, wdata;
  logic rsp_last, rsp_err;
  logic [IW-1:0] arid, awid;
  logic [AW-1:0] araddr, awaddr;
  logic [7:0] arlen, awlen;
  logic [2:0] arsize, awsize;
  logic [1:0] arburst, awburst, rresp, bresp;
  logic [SW-1:0] wstrb;
  logic arvalid, arready, rvalid, rready, rlast, awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    int p; logic w; logic [63:0] a, d; logic [7:0] s; logic [63:0] rd; logic [1:0] resp;
    int aw_dly, w_dly; logic [63:0] exp_data; logic exp_err;
  } vec_t;
  vec_t tv[6];
  int rr, cg, egi, beat, evp;
  bit busy, cw, ad, wd, ev, el, ee;
  logic [63:0] ca, cd, ed;
  logic [7:0] cs, cl, slv_len;
  logic [N-1:0] eg;
  bit pend[N];
  logic pw[N];
  logic [63:0] pa[N], pd[N];
  logic [7:0] ps[N], pl[N];

  always #5 clk = ~clk;

  axi_mem_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_err(rsp_err),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_arburst(arburst), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, want, $time);
    end
  endtask

  function automatic logic [N-1:0] oh(input int p);
    return N'(1) << p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_slave();
    arready = 0; rvalid = 0; rlast = 0; rdata = '0; rresp = '0;
    awready = 0; wready = 0; bvalid = 0; bresp = '0;
  endtask

  task automatic set_req(input int p, input logic w, input logic [63:0] a, input logic [63:0] d,
                         input logic [7:0] s, input logic [7:0] l);
    req_write[p] = w;
    req_addr[p*AW +: AW] = a;
    req_wdata[p*DW +: DW] = d;
    req_wstrb[p*SW +: SW] = s;
    req_len[p*8 +: 8] = l;
  endtask

  task automatic rst_pulse();
    req_valid = '0;
    idle_slave();
    reset = 0;
    step();
    step();
    reset = 1;
    step();
  endtask

  task automatic chk_rst(input string nm);
    chk(nm, 128'({req_ready, rsp_valid, arvalid, rready, awvalid, wvalid, bready, rsp_last, rsp_err}), 128'(0));
    chk(nm, 128'({rsp_data, araddr}), 128'(0));
  endtask

  task automatic finish_rd(input int p, input logic [63:0] d);
    arready = 1;
    step();
    arready = 0;
    rvalid = 1; rdata = d; rlast = 1; rresp = 2'b00;
    step();
    idle_slave();
    #1;
    chk("rd_rsp", 128'({rsp_valid, rsp_data, rsp_last, rsp_err}), 128'({oh(p), d, 1'b1, 1'b0}));
  endtask

  task automatic single(input vec_t v);
    set_req(v.p, v.w, v.a, v.d, v.s, 8'd0);
    req_valid = oh(v.p);
    #1;
    chk("tv_grant", 128'(req_ready), 128'(oh(v.p)));
    step();
    req_valid = '0;
    #1;
    if (!v.w) begin
      chk("tv_ar", 128'({arvalid, arid, araddr, arlen, arsize, arburst}), 128'({1'b1, IW'(v.p), v.a, 8'd0, 3'd3, 2'b01}));
      arready = 1;
      step();
      arready = 0;
      rvalid = 1; rdata = v.rd; rresp = v.resp; rlast = 1;
      #1;
      chk("tv_rready", 128'({arvalid, rready}), 128'(2'b01));
      step();
      idle_slave();
    end else begin
      chk("tv_aw", 128'({awid, awaddr, awlen, awsize, awburst, wlast}), 128'({IW'(v.p), v.a, 8'd0, 3'd3, 2'b01, 1'b1}));
      chk("tv_w", 128'({wdata, wstrb}), 128'({v.d, v.s}));
      for (int c = 0; c <= (v.aw_dly > v.w_dly ? v.aw_dly : v.w_dly); c++) begin
        awready = (c == v.aw_dly);
        wready = (c == v.w_dly);
        #1;
        chk("tv_valids", 128'({awvalid, wvalid, bready}), 128'({c <= v.aw_dly, c <= v.w_dly, 1'b0}));
        step();
      end
      awready = 0; wready = 0;
      bvalid = 1; bresp = v.resp;
      #1;
      chk("tv_bready", 128'({awvalid, wvalid, bready}), 128'(3'b001));
      step();
      idle_slave();
    end
    chk("tv_rsp", 128'({rsp_valid, rsp_data, rsp_last, rsp_err}), 128'({oh(v.p), v.exp_data, 1'b1, v.exp_err}));
    step();
    chk("tv_rsp_pulse", 128'(rsp_valid), 128'(0));
  endtask

  initial begin
    tv[0] = '{1, 1'b0, 64'h8000_0040, 64'h0, 8'h00, 64'hDEADBEEF_CAFEF00D, 2'b00, 0, 0, 64'hDEADBEEF_CAFEF00D, 1'b0};
    tv[1] = '{0, 1'b0, 64'h0000_0100, 64'h0, 8'h00, 64'h0123_4567_89AB_CDEF, 2'b11, 0, 0, 64'h0123_4567_89AB_CDEF, 1'b1};
    tv[2] = '{1, 1'b1, 64'h0000_2000, 64'h1122334455667788, 8'h0F, 64'h0, 2'b10, 2, 0, 64'h0, 1'b1};
    tv[3] = '{0, 1'b1, 64'h0000_3008, 64'hA5A5_5A5A_0F0F_F0F0, 8'hF0, 64'h0, 2'b00, 0, 0, 64'h0, 1'b0};
    tv[4] = '{0, 1'b1, 64'h0000_4010, 64'hFFFF_0000_1234_5678, 8'hFF, 64'h0, 2'b00, 0, 3, 64'h0, 1'b0};
    tv[5] = '{1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 2'b01, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    reset = 0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0; req_len = '0;
    idle_slave();
    #2;
    req_valid = '1;
    #1;
    chk_rst("reset_state");
    step();
    req_valid = '0;
    reset = 1;
    step();
    for (int i = 0; i < 6; i++) single(tv[i]);
    // burst read on port 0, four back-to-back beats
    set_req(0, 1'b0, 64'h4000, 64'h0, 8'h0, 8'd3);
    req_valid = 2'b01;
    #1;
    chk("burst_grant", 128'(req_ready), 128'(2'b01));
    step();
    req_valid = '0;
    #1;
    chk("burst_arlen", 128'({arvalid, arlen}), 128'({1'b1, 8'd3}));
    arready = 1;
    step();
    arready = 0;
    for (int b = 0; b < 4; b++) begin
      rvalid = 1; rdata = 64'(16 * (b + 1)); rlast = (b == 3);
      step();
      chk("burst_beat", 128'({rsp_valid, rsp_data, rsp_last, rsp_err}), 128'({2'b01, 64'(16 * (b + 1)), b == 3, 1'b0}));
    end
    idle_slave();
    #1;
    chk("burst_idle", 128'({arvalid, rready}), 128'(0));
    // stalled AR with the other port waiting; port 1 owns the turn after port 0's burst
    set_req(1, 1'b0, 64'h5000, 64'h0, 8'h0, 8'd0);
    set_req(0, 1'b0, 64'h6000, 64'h0, 8'h0, 8'd0);
    req_valid = 2'b11;
    #1;
    chk("stall_grant", 128'(req_ready), 128'(2'b10));
    step();
    req_valid = 2'b01;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("stall_ar", 128'({arvalid, araddr, arid, req_ready}), 128'({1'b1, 64'h5000, 13'd1, 2'b00}));
      step();
    end
    finish_rd(1, 64'h5555);
    chk("stall_next_grant", 128'(req_ready), 128'(2'b01));
    step();
    req_valid = '0;
    finish_rd(0, 64'h6666);
    // round robin with both ports held high
    rst_pulse();
    set_req(0, 1'b0, 64'hA000, 64'h0, 8'h0, 8'd0);
    set_req(1, 1'b0, 64'hB000, 64'h0, 8'h0, 8'd0);
    req_valid = 2'b11;
    for (int t = 0; t < 4; t++) begin
      #1;
      chk("rr_grant", 128'(req_ready), 128'(oh(t % 2)));
      step();
      #1;
      chk("rr_ar", 128'({arid, araddr}), 128'({IW'(t % 2), (t % 2) != 0 ? 64'hB000 : 64'hA000}));
      finish_rd(t % 2, 64'(t + 100));
    end
    req_valid = '0;
    step();
    // reset in the middle of a read burst
    set_req(0, 1'b0, 64'h7000, 64'h0, 8'h0, 8'd3);
    req_valid = 2'b01;
    step();
    req_valid = '0;
    arready = 1;
    step();
    arready = 0;
    rvalid = 1; rdata = 64'h77; rlast = 0;
    step();
    chk("midrd_beat", 128'(rsp_valid), 128'(2'b01));
    #2;
    reset = 0;
    req_valid = 2'b11;
    #1;
    chk_rst("midrd_async");
    step();
    chk("midrd_no_rsp", 128'({rsp_valid, rready, arvalid}), 128'(0));
    idle_slave();
    step();
    reset = 1;
    set_req(0, 1'b0, 64'h1000, 64'h0, 8'h0, 8'd0);
    #1;
    chk("midrd_regrant", 128'(req_ready), 128'(2'b01));
    step();
    req_valid = '0;
    #1;
    chk("midrd_ar", 128'({arvalid, arid, araddr}), 128'({1'b1, 13'd0, 64'h1000}));
    finish_rd(0, 64'h1000_0001);
    // randomized traffic against the reference model
    rst_pulse();
    rr = 0; busy = 0; ev = 0; ad = 0; wd = 0; cw = 0; beat = 0; slv_len = '0;
    for (int i = 0; i < N; i++) pend[i] = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(1, 0) == 1) begin
          pend[i] = 1;
          pw[i] = 1'($urandom_range(1, 0));
          pa[i] = {$urandom, $urandom};
          pd[i] = {$urandom, $urandom};
          ps[i] = 8'($urandom);
          pl[i] = 8'($urandom_range(3, 0));
          set_req(i, pw[i], pa[i], pd[i], ps[i], pl[i]);
        end
        req_valid[i] = pend[i];
      end
      arready = 1'($urandom_range(1, 0));
      awready = 1'($urandom_range(1, 0));
      wready = 1'($urandom_range(1, 0));
      rvalid = busy && !cw && ad && $urandom_range(2, 0) != 0;
      rdata = {$urandom, $urandom};
      rresp = $urandom_range(3, 0) == 0 ? 2'($urandom_range(3, 1)) : 2'b00;
      rlast = rvalid && beat == int'(slv_len);
      bvalid = busy && cw && ad && wd && $urandom_range(1, 0) == 1;
      bresp = $urandom_range(3, 0) == 0 ? 2'($urandom_range(3, 1)) : 2'b00;
      #1;
      egi = -1;
      if (!busy)
        for (int k = 0; k < N; k++)
          if (egi < 0 && pend[(rr + k) % N]) egi = (rr + k) % N;
      eg = egi < 0 ? N'(0) : oh(egi);
      chk("rnd_ready", 128'(req_ready), 128'(eg));
      chk("rnd_valids", 128'({arvalid, awvalid, wvalid, rready, bready}),
          128'({busy && !cw && !ad, busy && cw && !ad, busy && cw && !wd, busy && !cw && ad, busy && cw && ad && wd}));
      if (busy && !cw && !ad) chk("rnd_ar_fields", 128'({arid, araddr, arlen}), 128'({IW'(cg), ca, cl}));
      if (busy && cw && !ad) chk("rnd_aw_fields", 128'({awid, awaddr}), 128'({IW'(cg), ca}));
      if (busy && cw && !wd) chk("rnd_w_fields", 128'({wdata, wstrb}), 128'({cd, cs}));
      chk("rnd_rsp_valid", 128'(rsp_valid), 128'(ev ? oh(evp) : N'(0)));
      if (ev) chk("rnd_rsp", 128'({rsp_data, rsp_last, rsp_err}), 128'({ed, el, ee}));
      ev = 0;
      if (!busy) begin
        if (egi >= 0) begin
          busy = 1; cg = egi; cw = pw[egi]; ca = pa[egi]; cd = pd[egi]; cs = ps[egi]; cl = pl[egi];
          ad = 0; wd = 0; beat = 0; pend[egi] = 0; rr = (egi + 1) % N;
        end
      end else if (!cw) begin
        if (!ad && arready) begin
          ad = 1;
          slv_len = arlen;
        end else if (ad && rvalid) begin
          ev = 1; evp = cg; ed = rdata; el = rlast; ee = rresp != 0;
          beat++;
          if (rlast) busy = 0;
        end
      end else begin
        if (ad && wd && bvalid) begin
          ev = 1; evp = cg; ed = '0; el = 1; ee = bresp != 0; busy = 0;
        end
        if (!ad && awready) ad = 1;
        if (!wd && wready) wd = 1;
      end
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
